pad_reader: RTL
===============

// Module: pad_reader
// PURPOSE
//  Multi-port NES/SNES serial gamepad reader; successor to the single-port 8-bit reader.
//  Drives one shared latch/clock pair and samples NUM_PADS data lines in parallel.
//  Supports 8-bit (NES) or 16-bit (SNES) frames, a free-running auto-poll mode, and press/release edge events.
//  Sits between board pad pins and game logic; one frame per request or per poll period.
// PARAMETERS
//  CYCLES_PER_PULSE  150  clk cycles per half bit period (6 us at 25 MHz); must be >= 2
//  NUM_BITS          8    bits per frame: 8 = NES, 16 = SNES; legal range 2..16
//  NUM_PADS          2    number of data inputs read in parallel; legal range 1..4
//  POLL_CYCLES       0    auto-poll period in clk cycles; 0 = manual requests only
// PORTS
//  clk                 in   1                  system clock
//  i_rst               in   1                  synchronous, active-high reset
//  i_read_buttons      in   1                  one-cycle request to start a frame
//  i_auto_poll_en      in   1                  enables the POLL_CYCLES timer (ignored if POLL_CYCLES==0)
//  o_busy              out  1                  high from the first LATCH cycle to the DONE cycle, inclusive
//  o_valid             out  1                  one-cycle pulse: o_buttons/o_pressed/o_released updated
//  o_buttons           out  NUM_PADS*NUM_BITS  active-high button state; pad p = [p*NUM_BITS +: NUM_BITS]
//  o_pressed           out  NUM_PADS*NUM_BITS  new & ~previous, meaningful only while o_valid
//  o_released          out  NUM_PADS*NUM_BITS  ~new & previous, meaningful only while o_valid
//  i_controller_data   in   NUM_PADS           pad serial data, active low
//  o_controller_latch  out  1                  shared latch, active high
//  o_controller_clock  out  1                  shared clock, idles high
// BEHAVIOUR
//  Reset values: latch=0, clock=1, o_busy=0, o_valid=0, o_buttons=0, o_pressed=0, o_released=0.
//  The previous-state register and the pending flag also reset to 0.
//  Reset mid-frame aborts the frame immediately; no o_valid is produced.
//  States: IDLE -> LATCH -> SHIFT -> DONE -> IDLE. P = CYCLES_PER_PULSE; each bit occupies 2P cycles.
//  IDLE: if the start condition is true at edge N, enter LATCH with latch=1 at edge N+1.
//  LATCH (bit 0): latch high for P cycles, then low for P cycles.
//    Sample all data lines at in-bit count 3P/2-1 (integer division).
//  SHIFT (bits 1..NUM_BITS-1): clock low for P cycles, then high for P cycles.
//    Sample at in-bit count 3P/2-1.
//  DONE: a single cycle with o_valid=1, o_busy=1 and the outputs updated.
//    The previous-state register is loaded with the new frame.
//    o_valid therefore rises at edge N+1+2P*NUM_BITS.
//  Sampling: each pad has its own shift register. Sampled bit = ~i_controller_data[p]; shift is {sr, bit}.
//    The first-read bit (NES A / SNES B) lands in MSB NUM_BITS-1.
//  o_buttons is double-buffered: it holds the previous frame throughout a read and changes only in DONE.
//  Start condition: (i_read_buttons | pending | poll_tick) while in IDLE.
//  A request arriving while busy sets a 1-deep pending flag.
//    The flag is cleared when its frame starts, so the next frame starts the cycle after DONE.
//    Multiple requests during one frame coalesce into a single pending frame.
//  Auto-poll: a POLL_CYCLES counter runs while i_auto_poll_en=1.
//    It reloads on each expiry and resets to 0 while disabled.
//    Expiry generates poll_tick. If busy at expiry, poll_tick sets pending.
//    If POLL_CYCLES < 2P*NUM_BITS+2, frames run back-to-back.
//  Request and poll expiry in the same cycle start exactly one frame.
//  Counter widths: $clog2 of the maximum count + 1. All compares use sized constants (no lint width warnings).
// STRUCTURE
//  Shared header pad_reader.vh holds the state encodings (ST_IDLE, ST_LATCH, ST_SHIFT, ST_DONE).
//  The same header holds the NES/SNES frame length constants.
//  Sub-module pad_shifter (x NUM_PADS, generate loop), containing:
//    the NUM_BITS shift register, the output buffer, the previous-state register, and the pressed/released logic.
//  pad_shifter takes sample_en and commit_en from the top-level FSM/timing.
// TESTING (P=4, NUM_BITS=8, NUM_PADS=2, POLL_CYCLES=0 unless noted)
//  1 Manual read: pad0 low only in bit 0, pad1 all high; request at edge N.
//    Expect o_valid at N+65, o_buttons=16'h0080, latch high N+1..N+4, 7 clock-low pulses of 4 cycles.
//  2 Edge events: frame 1 pad0 = 8'h81, frame 2 pad0 = 8'h01.
//    Expect o_pressed[7:0]=8'h81 then 8'h00; o_released[7:0]=8'h00 then 8'h80.
//  3 Pending: a second request mid-frame, plus a third request in the same frame.
//    Expect exactly 2 o_valid pulses; the second frame's latch rises the cycle after the first DONE.
//  4 Auto-poll with POLL_CYCLES=100, enable held high.
//    Expect o_valid every 100 cycles; deasserting enable stops polling after the frame in flight completes.
//  5 Reset at in-frame cycle 30: the next cycle shows latch=0, clock=1, o_busy=0.
//    No o_valid follows; o_buttons=0.
//  6 SNES (NUM_BITS=16): pad0 low in bits 0 and 15. Expect o_buttons[15:0]=16'h8001, o_valid at N+129.

Source files
------------

// File: rtl/pad_reader_pkg.sv
// Shared definitions for the NES/SNES pad reader.
//   state_e   : frame sequencer states (idle -> latch -> shift -> done)
//   NES_BITS  : frame length of an NES controller
//   SNES_BITS : frame length of an SNES controller (also the widest frame supported)
package pad_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned NES_BITS  = 8;
    localparam int unsigned SNES_BITS = 16;

endpackage

// File: rtl/pad_reader_shifter.sv
// Per-pad capture: serial shift register, double-buffered button state and
// press/release edge detection.
//   clk          : system clock
//   i_rst        : synchronous, active-high reset
//   i_sample_en  : shift in one (inverted) data bit this cycle
//   i_commit_en  : frame complete; publish shift register and edge events
//   i_data_n     : pad serial data, active low
//   o_buttons    : last committed frame, active high, first-read bit in MSB
//   o_pressed    : new & ~previous, updated on commit
//   o_released   : ~new & previous, updated on commit
module pad_reader_shifter
    import pad_reader_pkg::*;
#(
    parameter int unsigned NUM_BITS = NES_BITS
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_sample_en,
    input  logic                i_commit_en,
    input  logic                i_data_n,
    output logic [NUM_BITS-1:0] o_buttons,
    output logic [NUM_BITS-1:0] o_pressed,
    output logic [NUM_BITS-1:0] o_released
);

    logic [NUM_BITS-1:0] r_shift;
    // The published button register also serves as the previous-frame
    // reference: both are loaded with the same value on every commit.
    logic [NUM_BITS-1:0] r_buttons;
    logic [NUM_BITS-1:0] r_pressed;
    logic [NUM_BITS-1:0] r_released;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_shift    <= '0;
            r_buttons  <= '0;
            r_pressed  <= '0;
            r_released <= '0;
        end else begin
            if (i_sample_en) begin
                r_shift <= {r_shift[NUM_BITS-2:0], ~i_data_n};
            end
            if (i_commit_en) begin
                r_buttons  <= r_shift;
                r_pressed  <= r_shift & ~r_buttons;
                r_released <= ~r_shift & r_buttons;
            end
        end
    end

    assign o_buttons  = r_buttons;
    assign o_pressed  = r_pressed;
    assign o_released = r_released;

endmodule

// File: rtl/pad_reader.sv
// Multi-port NES/SNES serial gamepad reader. One shared latch/clock pair,
// NUM_PADS data lines sampled in parallel, manual or auto-polled frames.
//   clk                : system clock
//   i_rst              : synchronous, active-high reset
//   i_read_buttons     : one-cycle frame request
//   i_auto_poll_en     : enables the POLL_CYCLES timer
//   o_busy             : high from first latch cycle through the done cycle
//   o_valid            : one-cycle pulse when outputs update
//   o_buttons          : active-high state, pad p at [p*NUM_BITS +: NUM_BITS]
//   o_pressed          : rising button events, valid with o_valid
//   o_released         : falling button events, valid with o_valid
//   i_controller_data  : pad serial data, active low
//   o_controller_latch : shared latch, active high
//   o_controller_clock : shared clock, idles high
module pad_reader
    import pad_reader_pkg::*;
#(
    parameter int unsigned CYCLES_PER_PULSE = 150,
    parameter int unsigned NUM_BITS         = NES_BITS,
    parameter int unsigned NUM_PADS         = 2,
    parameter int unsigned POLL_CYCLES      = 0
) (
    input  logic                         clk,
    input  logic                         i_rst,
    input  logic                         i_read_buttons,
    input  logic                         i_auto_poll_en,
    output logic                         o_busy,
    output logic                         o_valid,
    output logic [NUM_PADS*NUM_BITS-1:0] o_buttons,
    output logic [NUM_PADS*NUM_BITS-1:0] o_pressed,
    output logic [NUM_PADS*NUM_BITS-1:0] o_released,
    input  logic [NUM_PADS-1:0]          i_controller_data,
    output logic                         o_controller_latch,
    output logic                         o_controller_clock
);

    localparam int unsigned P     = CYCLES_PER_PULSE;
    localparam int unsigned CYC_W = $clog2(2 * P);
    localparam int unsigned BIT_W = $clog2(NUM_BITS);

    localparam logic [CYC_W-1:0] CYC_HALF   = CYC_W'(P);
    localparam logic [CYC_W-1:0] CYC_SAMPLE = CYC_W'(3 * P / 2 - 1);
    localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(2 * P - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NUM_BITS - 1);

    state_e             r_state, w_state_d;
    logic [CYC_W-1:0]   r_cyc, w_cyc_d;
    logic [BIT_W-1:0]   r_bit, w_bit_d;
    logic               r_pending, w_pending_d;
    logic               r_latch, w_latch_d;
    logic               r_clock, w_clock_d;
    logic               w_start;
    logic               w_poll_tick;
    logic               w_sample_en;
    logic               w_commit_en;

    // Auto-poll timer: counts 0..POLL_CYCLES-1 while enabled, ticks on the last count.
    if (POLL_CYCLES > 0) begin : g_poll
        localparam int unsigned POLL_W = $clog2(POLL_CYCLES + 1);
        localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);

        logic [POLL_W-1:0] r_poll_cnt;

        always_ff @(posedge clk) begin
            if (i_rst || !i_auto_poll_en) begin
                r_poll_cnt <= '0;
            end else if (r_poll_cnt == POLL_LAST) begin
                r_poll_cnt <= '0;
            end else begin
                r_poll_cnt <= r_poll_cnt + 1'b1;
            end
        end

        assign w_poll_tick = i_auto_poll_en && (r_poll_cnt == POLL_LAST);
    end else begin : g_no_poll
        logic w_unused_poll_en;
        assign w_unused_poll_en = i_auto_poll_en;
        assign w_poll_tick      = 1'b0;
    end

    assign w_start = (r_state == ST_IDLE) && (i_read_buttons || r_pending || w_poll_tick);

    always_comb begin
        w_state_d   = r_state;
        w_cyc_d     = r_cyc;
        w_bit_d     = r_bit;
        w_sample_en = 1'b0;
        w_commit_en = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_d = ST_LATCH;
                    w_cyc_d   = '0;
                    w_bit_d   = '0;
                end
            end
            ST_LATCH, ST_SHIFT: begin
                w_sample_en = (r_cyc == CYC_SAMPLE);
                if (r_cyc == CYC_LAST) begin
                    w_cyc_d = '0;
                    if (r_bit == BIT_LAST) begin
                        w_state_d   = ST_DONE;
                        w_commit_en = 1'b1;
                    end else begin
                        w_state_d = ST_SHIFT;
                        w_bit_d   = r_bit + 1'b1;
                    end
                end else begin
                    w_cyc_d = r_cyc + 1'b1;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Requests/ticks while busy coalesce into one pending frame.
        w_pending_d = r_pending;
        if (w_start) begin
            w_pending_d = 1'b0;
        end else if ((i_read_buttons || w_poll_tick) && (r_state != ST_IDLE)) begin
            w_pending_d = 1'b1;
        end

        // Pin levels are registered from next-state so they are glitch-free.
        w_latch_d = (w_state_d == ST_LATCH) && (w_cyc_d < CYC_HALF);
        w_clock_d = !((w_state_d == ST_SHIFT) && (w_cyc_d < CYC_HALF));
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cyc     <= '0;
            r_bit     <= '0;
            r_pending <= 1'b0;
            r_latch   <= 1'b0;
            r_clock   <= 1'b1;
        end else begin
            r_state   <= w_state_d;
            r_cyc     <= w_cyc_d;
            r_bit     <= w_bit_d;
            r_pending <= w_pending_d;
            r_latch   <= w_latch_d;
            r_clock   <= w_clock_d;
        end
    end

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        pad_reader_shifter #(
            .NUM_BITS (NUM_BITS)
        ) u_shifter (
            .clk         (clk),
            .i_rst       (i_rst),
            .i_sample_en (w_sample_en),
            .i_commit_en (w_commit_en),
            .i_data_n    (i_controller_data[p]),
            .o_buttons   (o_buttons[p*NUM_BITS +: NUM_BITS]),
            .o_pressed   (o_pressed[p*NUM_BITS +: NUM_BITS]),
            .o_released  (o_released[p*NUM_BITS +: NUM_BITS])
        );
    end

    assign o_busy             = (r_state != ST_IDLE);
    assign o_valid            = (r_state == ST_DONE);
    assign o_controller_latch = r_latch;
    assign o_controller_clock = r_clock;

endmodule
